// File: rtl/sa_pkg.sv
// Shared constants and pipeline record for the suffix-array read arbiter.
package sa_pkg;

   localparam int unsigned SA_DEPTH   = 18;
   localparam int unsigned SA_ADDR_W  = 5;
   localparam int unsigned SA_ROW_W   = 1920;
   localparam int unsigned SA_ENTRY_W = 32;
   localparam int unsigned SA_ENTRIES = SA_ROW_W / SA_ENTRY_W;
   localparam int unsigned SA_IDX_W   = 6;
   localparam int unsigned SA_ID_W    = 3;

   // One SRAM read port's lookup travelling from grant to response.
   typedef struct packed {
      logic                valid;
      logic [SA_ID_W-1:0]  id;
      logic [SA_IDX_W-1:0] idx;
      logic                err;
   } sa_port_t;

endpackage

// File: rtl/rr_pick2.sv
// Combinational circular picker: first and second valid lanes starting at ptr.
module rr_pick2 #(
   parameter int unsigned N     = 4,
   parameter int unsigned PTR_W = $clog2(N)
) (
   input  logic [N-1:0]     valid,
   input  logic [PTR_W-1:0] ptr,
   output logic [N-1:0]     grant0,
   output logic [N-1:0]     grant1,
   output logic             found0,
   output logic             found1
);

   logic [PTR_W:0]   sum;
   logic [PTR_W-1:0] lane;

   always_comb begin
      grant0 = '0;
      grant1 = '0;
      found0 = 1'b0;
      found1 = 1'b0;
      sum    = '0;
      lane   = '0;
      for (int unsigned k = 0; k < N; k++) begin
         sum = {1'b0, ptr} + (PTR_W+1)'(k);
         if (sum >= (PTR_W+1)'(N)) sum = sum - (PTR_W+1)'(N);
         lane = PTR_W'(sum);
         if (valid[lane]) begin
            if (!found0) begin
               grant0[lane] = 1'b1;
               found0       = 1'b1;
            end else if (!found1) begin
               grant1[lane] = 1'b1;
               found1       = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/sa_read_arbiter.sv
// Round-robin sharing of the two sram_SA read ports among backward-search lanes,
// with a fixed two-cycle request-to-response pipeline.
module sa_read_arbiter
   import sa_pkg::*;
#(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DEPTH      = SA_DEPTH,
   parameter int unsigned ADDR_WIDTH = SA_ADDR_W,
   parameter int unsigned WIDTHS     = SA_ROW_W,
   parameter int unsigned ENTRY_W    = SA_ENTRY_W,
   parameter int unsigned IDX_W      = SA_IDX_W
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*IDX_W-1:0]      req_idx,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic [NUM_REQ-1:0]            rsp_valid,
   output logic [NUM_REQ-1:0]            rsp_err,
   output logic [NUM_REQ*ENTRY_W-1:0]    rsp_data,
   output logic                          sram_rEn,
   output logic [ADDR_WIDTH-1:0]         sram_rAddr0,
   output logic [ADDR_WIDTH-1:0]         sram_rAddr1,
   input  logic [WIDTHS-1:0]             sram_rData0,
   input  logic [WIDTHS-1:0]             sram_rData1
);

   localparam int unsigned PTR_W   = $clog2(NUM_REQ);
   localparam int unsigned ENTRIES = WIDTHS / ENTRY_W;

   logic [PTR_W-1:0]      ptr;
   logic [PTR_W-1:0]      ptrNext;
   logic [NUM_REQ-1:0]    validGated;
   logic [NUM_REQ-1:0]    grant [2];
   logic                  found [2];
   logic [ADDR_WIDTH-1:0] laneAddr [NUM_REQ];
   logic [IDX_W-1:0]      laneIdx  [NUM_REQ];
   logic [NUM_REQ-1:0]    laneErr;
   logic [ADDR_WIDTH-1:0] portAddr [2];
   sa_port_t              pick [2];
   sa_port_t              s1   [2];
   logic [WIDTHS-1:0]     rowData  [2];
   logic [ENTRY_W-1:0]    portEntry [2];
   logic [NUM_REQ-1:0]    hit;
   logic [NUM_REQ-1:0]    hitErr;
   logic [ENTRY_W-1:0]    hitData [NUM_REQ];

   // No grants may leak out while reset is held.
   assign validGated = req_valid & {NUM_REQ{rst_n}};

   rr_pick2 #(.N(NUM_REQ), .PTR_W(PTR_W)) u_pick (
      .valid  (validGated),
      .ptr    (ptr),
      .grant0 (grant[0]),
      .grant1 (grant[1]),
      .found0 (found[0]),
      .found1 (found[1])
   );

   always_comb begin
      laneErr = '0;
      for (int unsigned l = 0; l < NUM_REQ; l++) begin
         laneAddr[l] = req_addr[l*ADDR_WIDTH +: ADDR_WIDTH];
         laneIdx[l]  = req_idx[l*IDX_W +: IDX_W];
         laneErr[l]  = !((32'(laneAddr[l]) < DEPTH) && (32'(laneIdx[l]) < ENTRIES));
      end
   end

   // Collapse each grant one-hot into the fields that drive the port and stage 1.
   always_comb begin
      for (int unsigned p = 0; p < 2; p++) begin
         pick[p]     = '0;
         portAddr[p] = '0;
         for (int unsigned l = 0; l < NUM_REQ; l++) begin
            if (grant[p][l]) begin
               pick[p].valid = 1'b1;
               pick[p].id    = SA_ID_W'(l);
               pick[p].err   = laneErr[l];
               pick[p].idx   = laneErr[l] ? '0 : SA_IDX_W'(laneIdx[l]);
               portAddr[p]   = laneErr[l] ? '0 : laneAddr[l];
            end
         end
      end
   end

   assign req_ready   = grant[0] | grant[1];
   assign sram_rEn    = found[0] | found[1];
   assign sram_rAddr0 = portAddr[0];
   assign sram_rAddr1 = portAddr[1];

   always_comb begin
      ptrNext = ptr;
      if (found[1]) begin
         ptrNext = (32'(pick[1].id) == NUM_REQ - 1) ? '0 : PTR_W'(32'(pick[1].id) + 1);
      end else if (found[0]) begin
         ptrNext = (32'(pick[0].id) == NUM_REQ - 1) ? '0 : PTR_W'(32'(pick[0].id) + 1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr   <= '0;
         s1[0] <= '0;
         s1[1] <= '0;
      end else begin
         ptr   <= ptrNext;
         s1[0] <= pick[0];
         s1[1] <= pick[1];
      end
   end

   assign rowData[0] = sram_rData0;
   assign rowData[1] = sram_rData1;

   // Entry extraction and routing of each port's result to its lane.
   always_comb begin
      hit    = '0;
      hitErr = '0;
      for (int unsigned p = 0; p < 2; p++) begin
         portEntry[p] = s1[p].err ? '0 : rowData[p][32'(s1[p].idx) * ENTRY_W +: ENTRY_W];
      end
      for (int unsigned l = 0; l < NUM_REQ; l++) begin
         hitData[l] = '0;
         for (int unsigned p = 0; p < 2; p++) begin
            if (s1[p].valid && (s1[p].id == SA_ID_W'(l))) begin
               hit[l]     = 1'b1;
               hitErr[l]  = s1[p].err;
               hitData[l] = portEntry[p];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid <= '0;
         rsp_err   <= '0;
         rsp_data  <= '0;
      end else begin
         rsp_valid <= hit;
         for (int unsigned l = 0; l < NUM_REQ; l++) begin
            if (hit[l]) begin
               rsp_err[l]                       <= hitErr[l];
               rsp_data[l*ENTRY_W +: ENTRY_W]   <= hitData[l];
            end
         end
      end
   end

endmodule

// File: tb/tb_sa_read_arbiter.sv
// Scoreboard bench for sa_read_arbiter: directed lookups against a behavioural sram_SA.
module tb_sa_read_arbiter;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [3:0]    req_valid = '0;
   logic [19:0]   req_addr = '0;
   logic [23:0]   req_idx = '0;
   logic [3:0]    req_ready;
   logic [3:0]    rsp_valid;
   logic [3:0]    rsp_err;
   logic [127:0]  rsp_data;
   logic          sram_rEn;
   logic [4:0]    sram_rAddr0;
   logic [4:0]    sram_rAddr1;
   logic [1919:0] sram_rData0 = '0;
   logic [1919:0] sram_rData1 = '0;

   typedef struct packed {
      logic        err;
      logic [31:0] data;
      logic [31:0] due;
   } exp_t;

   exp_t expQ [4][$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   sa_read_arbiter dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_addr    (req_addr),
      .req_idx     (req_idx),
      .req_ready   (req_ready),
      .rsp_valid   (rsp_valid),
      .rsp_err     (rsp_err),
      .rsp_data    (rsp_data),
      .sram_rEn    (sram_rEn),
      .sram_rAddr0 (sram_rAddr0),
      .sram_rAddr1 (sram_rAddr1),
      .sram_rData0 (sram_rData0),
      .sram_rData1 (sram_rData1)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [1919:0] mkRow(input int r);
      logic [1919:0] row;
      for (int k = 0; k < 60; k++) row[k*32 +: 32] = {8'(r), 8'(k), 16'hA5A5};
      return row;
   endfunction

   // Read data appears one cycle after rEn.
   always @(posedge clk) begin
      if (sram_rEn) begin
         sram_rData0 <= mkRow(int'(sram_rAddr0));
         sram_rData1 <= mkRow(int'(sram_rAddr1));
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Call right after a falling edge: drive one cycle's requests and check the grant side.
   task automatic drive(input logic [3:0] v, input logic [19:0] a, input logic [23:0] ix,
                        input logic [3:0] expRdy, input logic [4:0] expA0,
                        input logic [4:0] expA1, input bit doPush);
      int   r;
      int   k;
      exp_t e;
      req_valid = v;
      req_addr  = a;
      req_idx   = ix;
      #1;
      check("req_ready", 64'(req_ready), 64'(expRdy));
      check("sram_rEn", 64'(sram_rEn), 64'(|expRdy));
      check("sram_rAddr0", 64'(sram_rAddr0), 64'(expA0));
      check("sram_rAddr1", 64'(sram_rAddr1), 64'(expA1));
      if (doPush) begin
         for (int l = 0; l < 4; l++) begin
            if (expRdy[l]) begin
               r      = int'(a[l*5 +: 5]);
               k      = int'(ix[l*6 +: 6]);
               e.err  = (r >= 18) || (k >= 60);
               e.data = e.err ? 32'h0 : {8'(r), 8'(k), 16'hA5A5};
               e.due  = 32'(cyc + 2);
               expQ[l].push_back(e);
            end
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         drive(4'b0000, '0, '0, 4'b0000, 5'd0, 5'd0, 1'b0);
      end
   endtask

   // Monitor: every response pulse must match the head of that lane's queue on time.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         for (int l = 0; l < 4; l++) begin
            if (rsp_valid[l]) begin
               if (expQ[l].size() == 0) begin
                  check($sformatf("rsp_unexpected[%0d]", l), 64'(rsp_valid[l]), 64'(0));
               end else begin
                  e = expQ[l].pop_front();
                  check($sformatf("rsp_cycle[%0d]", l), 64'(cyc), 64'(e.due));
                  check($sformatf("rsp_err[%0d]", l), 64'(rsp_err[l]), 64'(e.err));
                  check($sformatf("rsp_data[%0d]", l), 64'(rsp_data[l*32 +: 32]), 64'(e.data));
               end
            end else if (expQ[l].size() != 0 && int'(expQ[l][0].due) <= cyc) begin
               check($sformatf("rsp_missing[%0d]", l), 64'(rsp_valid[l]), 64'(1));
               void'(expQ[l].pop_front());
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset held with every lane requesting: nothing may be granted.
      req_valid = 4'hF;
      req_addr  = {5'd4, 5'd3, 5'd2, 5'd1};
      req_idx   = {6'd13, 6'd12, 6'd11, 6'd10};
      repeat (3) @(negedge clk);
      #1;
      check("reset_req_ready", 64'(req_ready), 64'(0));
      check("reset_rsp_valid", 64'(rsp_valid), 64'(0));
      check("reset_sram_rEn", 64'(sram_rEn), 64'(0));
      check("reset_rAddr0", 64'(sram_rAddr0), 64'(0));
      check("reset_rsp_data", 64'(rsp_data[63:0]), 64'(0));

      // Release and hold all four lanes for four cycles: {0,1},{2,3},{0,1},{2,3}.
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         if (c != 0) @(negedge clk);
         drive(4'hF, {5'd4, 5'd3, 5'd2, 5'd1}, {6'd13, 6'd12, 6'd11, 6'd10},
               (c % 2 == 1) ? 4'b1100 : 4'b0011,
               (c % 2 == 1) ? 5'd3 : 5'd1, (c % 2 == 1) ? 5'd4 : 5'd2, 1'b1);
      end
      idle(4);

      // Single requester lands on port 0.
      @(negedge clk);
      drive(4'b0100, {5'd0, 5'd3, 5'd0, 5'd0}, {6'd0, 6'd59, 6'd0, 6'd0},
            4'b0100, 5'd3, 5'd0, 1'b1);
      idle(3);
      check("single_lane2_data", 64'(rsp_data[95:64]), 64'(32'h033BA5A5));

      // Out-of-range row on lane 1 and index on lane 3; pointer now at 3.
      @(negedge clk);
      drive(4'b1010, {5'd2, 5'd0, 5'd18, 5'd0}, {6'd60, 6'd0, 6'd0, 6'd0},
            4'b1010, 5'd0, 5'd0, 1'b1);
      idle(3);
      check("err_flags", 64'(rsp_err), 64'(4'b1010));
      check("held_lane2_data", 64'(rsp_data[95:64]), 64'(32'h033BA5A5));

      // Wrap-around from pointer 2: lane 3 on port 0, lane 0 on port 1.
      @(negedge clk);
      drive(4'b1001, {5'd9, 5'd0, 5'd0, 5'd6}, {6'd8, 6'd0, 6'd0, 6'd7},
            4'b1001, 5'd9, 5'd6, 1'b1);
      idle(3);

      // Same row on both ports; pointer at 1 puts lane 1 on port 0.
      @(negedge clk);
      drive(4'b0011, {5'd0, 5'd0, 5'd5, 5'd5}, {6'd0, 6'd0, 6'd1, 6'd0},
            4'b0011, 5'd5, 5'd5, 1'b1);
      idle(3);
      check("same_row_lane0", 64'(rsp_data[31:0]), 64'(32'h0500A5A5));
      check("same_row_lane1", 64'(rsp_data[63:32]), 64'(32'h0501A5A5));

      // Reset one cycle after a grant: the lookup must vanish and the pointer return to 0.
      @(negedge clk);
      drive(4'b0001, {5'd0, 5'd0, 5'd0, 5'd7}, {6'd0, 6'd0, 6'd0, 6'd5},
            4'b0001, 5'd7, 5'd0, 1'b0);
      @(negedge clk);
      rst_n     = 1'b0;
      req_valid = 4'b0000;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      idle(4);
      @(negedge clk);
      drive(4'hF, {5'd4, 5'd3, 5'd2, 5'd1}, {6'd13, 6'd12, 6'd11, 6'd10},
            4'b0011, 5'd1, 5'd2, 1'b1);
      idle(4);

      for (int l = 0; l < 4; l++) begin
         check($sformatf("drain_lane%0d", l), 64'(expQ[l].size()), 64'(0));
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sa_read_arbiter.md
# sa_read_arbiter

Round-robin arbiter that shares the two read ports of the suffix-array SRAM (`sram_SA`) between `NUM_REQ` backward-search lanes. Each cycle it grants up to two pending lookups, drives the SRAM read ports, and extracts the requested `ENTRY_W`-bit entry from the returned row. It then routes the entry back to the originating lane with a fixed latency. It sits between the exact-match lanes and `sram_SA`; the SRAM write port is not touched.

## Interface
- `NUM_REQ`, 4: number of requesting lanes (2..8).
- `DEPTH`, 18: SRAM rows.
- `ADDR_WIDTH`, 5: row address width.
- `WIDTHS`, 1920: SRAM row width.
- `ENTRY_W`, 32: SA entry width; `WIDTHS/ENTRY_W` = 60 entries per row.
- `IDX_W`, 6: entry-index width.

Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  per-lane lookup request.
- `req_addr`  in  NUM_REQ*ADDR_WIDTH  packed row addresses; lane i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- `req_idx`  in  NUM_REQ*IDX_W  packed entry indices.
- `req_ready`  out  NUM_REQ  combinational grant; handshake completes when valid&ready.
- `rsp_valid`  out  NUM_REQ  one-cycle response pulse per lane.
- `rsp_err`  out  NUM_REQ  out-of-range flag, qualified by rsp_valid.
- `rsp_data`  out  NUM_REQ*ENTRY_W  packed per-lane entry, registered.
- `sram_rEn`  out  1  to SRAM rEn.
- `sram_rAddr0`, `sram_rAddr1`  out  ADDR_WIDTH  to SRAM read addresses.
- `sram_rData0`, `sram_rData1`  in  WIDTHS  from SRAM; valid one cycle after rEn.

## Operation
- **Request rule:** a lane holds `req_valid`, `req_addr` and `req_idx` stable until `req_ready`. Lanes have no response backpressure; they must accept `rsp_valid` when it arrives.
- **Picking:** a round-robin pointer `ptr` (0..NUM_REQ-1) is kept. Each cycle, the valid lanes are scanned circularly from `ptr`.
  - The first valid lane goes to port 0 and the second to port 1.
  - A lane is never granted twice in one cycle.
- **Pointer update:** `ptr` becomes (last granted lane + 1) mod NUM_REQ. With no grant, `ptr` is unchanged.
- **SRAM drive:** `sram_rEn` = any grant. An unused port drives address 0.
- **Range check:** a request with `req_addr >= DEPTH` or `req_idx >= WIDTHS/ENTRY_W` is still granted and consumes its port slot.
  - Its port address is forced to 0.
  - Its response carries `rsp_err=1` and `rsp_data=0`.
- **Stage 1 register:** per port, store {valid, lane id, idx, err}.
- **Stage 2:** on the cycle after the grant, select entry `idx` of the matching `sram_rData` port, i.e. bits [idx*ENTRY_W +: ENTRY_W]. Register it into the lane's `rsp_data`, and set `rsp_valid`/`rsp_err` for that lane.
- **Held data:** `rsp_data` keeps its last value when `rsp_valid` is low.
- **Same row on both ports:** legal, and both lanes get correct entries.
- **Write collision:** a read of a row written in the same cycle returns the old row (SRAM behaviour). This is not checked.

## Timing
- Grant in cycle T (combinational `req_ready`), SRAM read registered at T+1, response registered at T+2. Fixed 2-cycle request-to-response latency.
- Throughput is 2 lookups/cycle. Back-to-back grants to the same lane in consecutive cycles are allowed.
- **Reset values:**
  - `ptr`=0.
  - Stage-1 valids 0.
  - `rsp_valid`=0, `rsp_err`=0, `rsp_data`=0.
  - `sram_rEn`=0 and `sram_rAddr0/1`=0; these are combinational from grants, and `req_ready`=0 while `rst_n` is low.
- **Reset mid-operation:** all in-flight lookups are dropped. No `rsp_valid` appears for them after reset releases.
- **Single requester:** always granted on port 0; port 1 is idle.

## Structure
- Package `sa_pkg`:
  - constants `SA_DEPTH`, `SA_ADDR_W`, `SA_ROW_W`, `SA_ENTRY_W`, `SA_IDX_W`, `SA_ENTRIES`;
  - a per-port pipeline record type {valid, id, idx, err}.
- Sub-module `rr_pick2`: a combinational two-winner circular picker. Inputs are the valid vector and `ptr`; outputs are the two grant one-hots plus their found flags. The top owns `ptr` and both pipeline stages.

## Test plan
Bench SRAM model: row r, entry k = {8'(r), 8'(k), 16'hA5A5}.
- **Reset:** hold `rst_n`=0 with all lanes valid → `req_ready`=0, `rsp_valid`=0 and `sram_rEn`=0. After release, the first grants go to lanes 0 and 1.
- **Single lookup:** lane 2 requests row 3, idx 59 → `sram_rAddr0`=3 at T; at T+2 `rsp_valid[2]`=1 with `rsp_data` lane 2 = 32'h033BA5A5.
- **All 4 lanes held valid for 4 cycles:** grant pairs are {0,1}, {2,3}, {0,1}, {2,3}, and 8 responses arrive in the same order at +2 cycles.
- **Out of range:** lane 1 requests row 18 and lane 3 requests idx 60 → both granted; at T+2 `rsp_err` is set for lanes 1 and 3 with data 0, and `sram_rAddr` is 0.
- **Same row:** lanes 0 and 1 both request row 5, idx 0 and idx 1 → 32'h0500A5A5 and 32'h0501A5A5 in the same cycle.
- **Reset mid-flight:** assert `rst_n` low one cycle after a grant → no response pulses after release; `ptr` is 0.
